// File: rtl/note_sequencer.sv
// note_sequencer
//   Programmable step sequencer driving the 6-bit note index of the frequency
//   selector. Holds DEPTH pattern entries {rest, note[5:0], dur[5:0]} and plays
//   them in order. Each step lasts dur tempo ticks of TICK_DIV clocks. With
//   GAP_EN set, the gate drops for the final tick of any step of two or more
//   ticks. Playback is one-shot, or looped when loop_en is high at the end of
//   the pattern.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset (pattern memory is kept)
//   wr_en        pattern write strobe, honoured only while idle
//   wr_addr      entry address
//   wr_data      {rest, note[5:0], dur[5:0]}; dur=0 terminates the pattern
//   start        begin playback at entry 0 (sampled while idle)
//   stop         abort playback; wins over start and over a step end
//   loop_en      wrap to entry 0 instead of finishing at end of pattern
//   freq_select  note index to the frequency selector (held through rests)
//   gate         note sounding
//   step         index of the entry being played
//   busy         playback active
//   done         one-cycle pulse on natural end of pattern
module note_sequencer #(
  parameter int DEPTH      = 16,
  parameter int TICK_DIV   = 250000,
  parameter int GAP_EN     = 1,
  parameter int RESET_NOTE = 33,
  localparam int AW = $clog2(DEPTH),
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [12:0]   wr_data,
  input  logic          start,
  input  logic          stop,
  input  logic          loop_en,
  output logic [5:0]    freq_select,
  output logic          gate,
  output logic [AW-1:0] step,
  output logic          busy,
  output logic          done
);

  typedef enum logic {S_IDLE, S_PLAY} state_t;

  state_t        state;
  logic [12:0]   mem [DEPTH];
  logic [TW-1:0] tick_cnt;
  logic [5:0]    dur_cnt;
  logic [5:0]    cur_dur;

  logic          tick;
  logic          step_last;
  logic          gap_next;
  logic [AW:0]   nxt;
  logic [AW-1:0] nxt_addr;
  logic          end_of_pat;
  logic [12:0]   e0;
  logic [12:0]   en;

  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [12:0]   ld_entry;
  logic          fin;

  // Pattern memory: no reset, so a pattern survives rst_n. Writes are locked
  // out during playback, which keeps every entry stable while it is read.
  always_ff @(posedge clk) begin
    if (wr_en && !busy) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign e0       = mem[0];
  assign nxt      = {1'b0, step} + (AW+1)'(1);
  assign nxt_addr = nxt[AW-1:0];
  assign en       = mem[nxt_addr];

  always_comb begin
    tick       = (tick_cnt == TW'(TICK_DIV - 1));
    step_last  = (dur_cnt == (cur_dur - 6'd1));
    // Gate drops on entering the final tick of a step of two or more ticks.
    gap_next   = (GAP_EN != 0) && (cur_dur >= 6'd2) &&
                 ((dur_cnt + 6'd1) == (cur_dur - 6'd1));
    // Wrap past the last entry or a dur=0 terminator both end the pattern.
    end_of_pat = (nxt == (AW+1)'(DEPTH)) || (en[5:0] == 6'd0);
  end

  // Decide whether a new step is loaded on this edge, and from which entry.
  always_comb begin
    ld_en    = 1'b0;
    ld_addr  = '0;
    ld_entry = e0;
    fin      = 1'b0;
    if (state == S_IDLE) begin
      if (start && !stop && (e0[5:0] != 6'd0)) begin
        ld_en = 1'b1;
      end
    end else if (!stop && tick && step_last) begin
      if (end_of_pat) begin
        if (loop_en) begin
          ld_en = 1'b1;
        end else begin
          fin = 1'b1;
        end
      end else begin
        ld_en    = 1'b1;
        ld_addr  = nxt_addr;
        ld_entry = en;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      freq_select <= 6'(RESET_NOTE);
      gate        <= 1'b0;
      step        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      tick_cnt    <= '0;
      dur_cnt     <= '0;
      cur_dur     <= '0;
    end else begin
      done <= 1'b0;
      if (ld_en) begin
        state    <= S_PLAY;
        busy     <= 1'b1;
        step     <= ld_addr;
        gate     <= ~ld_entry[12];
        cur_dur  <= ld_entry[5:0];
        tick_cnt <= '0;
        dur_cnt  <= '0;
        // A rest keeps the previous pitch so downstream stages see no glitch.
        if (!ld_entry[12]) begin
          freq_select <= ld_entry[11:6];
        end
      end else if (state == S_PLAY) begin
        if (stop || fin) begin
          state <= S_IDLE;
          busy  <= 1'b0;
          gate  <= 1'b0;
          done  <= fin && !stop;
        end else if (tick) begin
          tick_cnt <= '0;
          dur_cnt  <= dur_cnt + 6'd1;
          if (gap_next) begin
            gate <= 1'b0;
          end
        end else begin
          tick_cnt <= tick_cnt + TW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
module tb_note_sequencer;

  localparam int T = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [12:0] wr_data;
  logic       start;
  logic       stop;
  logic       loop_en;
  logic [5:0] freq_select;
  logic       gate;
  logic [3:0] step;
  logic       busy;
  logic       done;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  note_sequencer #(
    .DEPTH(16), .TICK_DIV(T), .GAP_EN(1), .RESET_NOTE(33)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .stop(stop), .loop_en(loop_en),
    .freq_select(freq_select), .gate(gate), .step(step), .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  // Behavioural model: playback described as (entry, cycle offset in step).
  logic [12:0] mm [16];
  int          m_busy = 0;
  int          m_idx  = 0;
  int          m_off  = 0;
  int          m_freq = 33;
  int          m_done = 0;
  logic [12:0] m_ent  = '0;

  initial for (int i = 0; i < 16; i++) mm[i] = '0;

  function automatic void m_enter(int i);
    m_idx  = i;
    m_off  = 0;
    m_ent  = mm[i];
    m_busy = 1;
    if (!m_ent[12]) m_freq = int'(m_ent[11:6]);
  endfunction

  function automatic int m_gate();
    int d;
    d = int'(m_ent[5:0]);
    if (m_busy == 0 || m_ent[12]) return 0;
    if (d >= 2 && m_off >= (d - 1) * T) return 0;
    return 1;
  endfunction

  always @(negedge rst_n) begin
    m_busy = 0; m_idx = 0; m_off = 0; m_freq = 33; m_done = 0;
  end

  always @(posedge clk) begin
    bit wr_ok;
    int d;
    int nb;
    wr_ok = wr_en && (m_busy == 0);
    if (rst_n) begin
      m_done = 0;
      d = int'(m_ent[5:0]);
      if (m_busy == 0) begin
        if (start && !stop && mm[0][5:0] != 6'd0) m_enter(0);
      end else if (stop) begin
        m_busy = 0;
      end else if (m_off == d * T - 1) begin
        nb = m_idx + 1;
        if (nb == 16 || mm[nb % 16][5:0] == 6'd0) begin
          if (loop_en) m_enter(0);
          else begin m_busy = 0; m_done = 1; end
        end else begin
          m_enter(nb);
        end
      end else begin
        m_off++;
      end
    end
    if (wr_ok) mm[wr_addr] = wr_data;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("freq_select", int'(freq_select), m_freq);
      chk("gate", int'(gate), m_gate());
      chk("step", int'(step), m_idx);
      chk("busy", int'(busy), m_busy);
      chk("done", int'(done), m_done);
    end
  end

  // Stimulus helpers: all called and returning on a falling edge.
  task automatic wr(input int a, input int rest, input int note, input int dur);
    wr_en   = 1'b1;
    wr_addr = 4'(a);
    wr_data = {1'(rest), 6'(note), 6'(dur)};
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic load_pat();
    wr(0, 0, 24, 2);
    wr(1, 0, 28, 1);
    wr(2, 1, 50, 3);
    wr(3, 0, 0, 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Literal expectations for the three-step pattern at cycle c after start.
  task automatic chk_pat_lit(input int c);
    if (c < 8) begin
      chk("lit s0 freq", int'(freq_select), 24);
      chk("lit s0 gate", int'(gate), (c < 4) ? 1 : 0);
      chk("lit s0 step", int'(step), 0);
    end else if (c < 12) begin
      chk("lit s1 freq", int'(freq_select), 28);
      chk("lit s1 gate", int'(gate), 1);
      chk("lit s1 step", int'(step), 1);
    end else if (c < 24) begin
      chk("lit s2 freq", int'(freq_select), 28);
      chk("lit s2 gate", int'(gate), 0);
      chk("lit s2 step", int'(step), 2);
    end else begin
      chk("lit end busy", int'(busy), 0);
      chk("lit end done", int'(done), (c == 24) ? 1 : 0);
    end
    if (c < 24) chk("lit busy", int'(busy), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish by 200000");
    $fatal(1);
  end

  initial begin
    int cnt;
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; stop = 1'b0; loop_en = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;

    chk("reset freq", int'(freq_select), 33);
    chk("reset gate", int'(gate), 0);
    chk("reset step", int'(step), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);

    // Empty pattern: start is ignored.
    for (int i = 0; i < 16; i++) wr(i, 0, 0, 0);
    pulse_start();
    for (int c = 0; c < 5; c++) begin
      chk("empty busy", int'(busy), 0);
      chk("empty done", int'(done), 0);
      @(negedge clk);
    end

    // One-shot playback.
    load_pat();
    pulse_start();
    for (int c = 0; c < 26; c++) begin
      chk_pat_lit(c);
      @(negedge clk);
    end

    // Looped playback, loop dropped during step 1 of the second pass.
    loop_en = 1'b1;
    pulse_start();
    cnt = 0;
    for (int c = 0; c < 60; c++) begin
      if (c == 24) begin
        chk("loop wrap freq", int'(freq_select), 24);
        chk("loop wrap step", int'(step), 0);
        chk("loop wrap busy", int'(busy), 1);
      end
      if (c == 33) loop_en = 1'b0;
      if (c == 48) chk("loop finish done", int'(done), 1);
      if (done) cnt++;
      @(negedge clk);
    end
    chk("loop done pulses", cnt, 1);

    // Stop during step 1.
    pulse_start();
    repeat (9) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("stop busy", int'(busy), 0);
    chk("stop gate", int'(gate), 0);
    cnt = 0;
    for (int c = 0; c < 30; c++) begin
      if (done) cnt++;
      @(negedge clk);
    end
    chk("stop no done", cnt, 0);

    // Start and stop together while idle.
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    chk("start+stop busy", int'(busy), 0);
    @(negedge clk);

    // Start and a write while busy are both ignored.
    pulse_start();
    repeat (3) @(negedge clk);
    start = 1'b1;
    wr(0, 0, 40, 5);
    start = 1'b0;
    repeat (24) @(negedge clk);
    chk("busy-start idle", int'(busy), 0);
    pulse_start();
    for (int c = 0; c < 26; c++) begin
      chk_pat_lit(c);
      @(negedge clk);
    end

    // Asynchronous reset in the middle of a step.
    pulse_start();
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async freq", int'(freq_select), 33);
    chk("async gate", int'(gate), 0);
    chk("async step", int'(step), 0);
    chk("async busy", int'(busy), 0);
    chk("async done", int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    pulse_start();
    for (int c = 0; c < 26; c++) begin
      chk_pat_lit(c);
      @(negedge clk);
    end

    // Sixteen one-tick steps run to the wrap point and finish.
    for (int i = 0; i < 16; i++) wr(i, 0, i + 1, 1);
    pulse_start();
    cnt = 0;
    for (int c = 0; c < 80; c++) begin
      if (busy) cnt++;
      if (c == 60) chk("fill step15", int'(step), 15);
      if (c == 64) chk("fill done", int'(done), 1);
      @(negedge clk);
    end
    chk("fill busy cycles", cnt, 64);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      wr_en   = ($urandom_range(99) < 30);
      wr_addr = 4'($urandom_range(15));
      wr_data = {1'($urandom_range(99) < 20), 6'($urandom_range(63)),
                 6'(($urandom_range(99) < 10) ? 0 : $urandom_range(1, 3))};
      start   = ($urandom_range(99) < 5);
      stop    = ($urandom_range(99) < 1);
      if ($urandom_range(99) < 2) loop_en = ~loop_en;
      if (i == 1500) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    wr_en = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/note_sequencer.md
# note_sequencer

Programmable step sequencer that drives the 6-bit note index of the frequency selector. It stores up to DEPTH steps, each holding a note, a rest flag and a duration in tempo ticks, and plays them in order with an optional articulation gap. It supports one-shot or looped playback and outputs a gate for the downstream waveform/amplitude stage. It sits between the control interface (buttons/UART register writes) and the frequency selector + waveform generators.

## Interface
- DEPTH, 16: number of pattern entries; address width is clog2(DEPTH).
- TICK_DIV, 250000: clk cycles per tempo tick (10 ms at 25 MHz).
- GAP_EN, 1: 1 = gate drops for the final tick of each multi-tick step.
- RESET_NOTE, 33: freq_select value at reset (A4).

Ports (name, direction, width, meaning):
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  pattern write strobe (accepted only when busy=0)
- wr_addr  in  clog2(DEPTH)  entry address
- wr_data  in  13  {rest[12], note[11:6], dur[5:0]}; dur=0 marks end of pattern
- start  in  1  begin playback at entry 0 (level-sampled, idle only)
- stop  in  1  abort playback
- loop_en  in  1  restart at entry 0 at end of pattern instead of finishing
- freq_select  out  6  note index to frequency selector
- gate  out  1  note sounding
- step  out  clog2(DEPTH)  current entry index
- busy  out  1  playback active
- done  out  1  one-cycle pulse on natural end of pattern

## Operation
- Pattern memory: DEPTH x 13 registers, not cleared by reset; contents survive rst_n.
- Writes: wr_en with busy=0 stores wr_data at wr_addr on the clock edge; wr_en with busy=1 is ignored.
- FSM states: IDLE, PLAY.
  - IDLE -> PLAY: start=1, stop=0, and entry 0 has dur != 0.
  - start while entry 0 dur=0: ignored. No busy, no done.
- Entering a step: freq_select <= entry note, step <= index, gate <= ~rest, tick counters cleared.
  - A rest step holds the previous freq_select value, not the rest entry's note.
- Tick counter counts 0..TICK_DIV-1. A tick fires on the cycle the count equals TICK_DIV-1.
- Step tick counter counts 0..dur-1.
- Step ends on the tick where step tick count = dur-1. Next index = step+1.
- End of pattern: next index = DEPTH (wrap) or next entry dur=0.
  - loop_en=1: go to entry 0 (entry 0 dur is guaranteed nonzero since playback started).
  - loop_en=0: go to IDLE with done=1 for one cycle.
  - loop_en is sampled only at end of pattern.
- Articulation: with GAP_EN=1 and dur>=2, gate=0 during the final tick (step tick count = dur-1). With dur=1, no gap.
- stop=1 in PLAY: go to IDLE next cycle with gate=0 and no done. stop has priority over start and over a simultaneous step end.
- start while busy: ignored.
- IDLE outputs: gate=0, busy=0, freq_select and step hold their last values.
- Note values 60-63 are passed through unchanged; the selector maps them to its default.

## Timing
- Reset values: freq_select=RESET_NOTE, gate=0, step=0, busy=0, done=0, FSM=IDLE, counters=0. Reset is asynchronous mid-step; outputs go to reset values immediately.
- All outputs are registered.
- Start latency: start sampled at edge N; from cycle N+1, busy=1, step=0, and freq_select/gate show entry 0.
- Step k occupies exactly dur_k x TICK_DIV cycles. Successive steps are back-to-back with no dead cycle, including loop wrap.
- Natural end: the cycle after the last step's final cycle has busy=0, gate=0, done=1. done returns to 0 the following cycle.
- Stop: stop high at edge M; from cycle M+1, busy=0 and gate=0.

## Test plan
- Reset: assert rst_n=0 mid-simulation -> freq_select=33, gate=0, step=0, busy=0, done=0 immediately. Previously written pattern still plays correctly after release.
- One-shot with TICK_DIV=4. Pattern {note24,dur2}, {note28,dur1}, {rest,dur3}, {dur0}. Pulse start ->
  - step0 8 cycles, freq 24, gate 1 for 4 cycles then 0 for 4;
  - step1 4 cycles, freq 28, gate 1;
  - step2 12 cycles, freq 28, gate 0;
  - then done=1 for 1 cycle, busy=0.
- Loop: same pattern with loop_en=1 -> step2 is followed immediately by step0 with freq 24, no done. Drop loop_en during step1 -> pattern finishes and done pulses once.
- Stop and priority:
  - stop during step1 -> next cycle busy=0, gate=0, done never pulses.
  - start and stop in the same idle cycle -> busy stays 0.
  - start while busy -> step sequence unaffected.
- Write gating and wrap:
  - write during playback -> memory unchanged.
  - fill all 16 entries with dur=1, loop_en=0 -> steps 0..15 play, 64 cycles total, then done.
- Empty pattern: entry 0 dur=0, pulse start -> busy, gate and done all stay 0.
